// File: rtl/counter_capture_fifo.sv
// counter_capture_fifo: timestamps event_in edges with the counter value and queues them in a FIFO
// Ports: clk/rst (sync, active-high); counter = timebase; event_in = event line (clk domain);
//        cap_valid/cap_ready/cap_data = head entry handshake; cap_level = occupancy;
//        overflow = sticky drop flag, cleared by clear_overflow.
// Build option: define CAPTURE_DELTA_EN to queue (counter - last_capture) instead of absolute values.
module counter_capture_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int EDGE  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         counter,
  input  logic                     event_in,
  output logic                     cap_valid,
  input  logic                     cap_ready,
  output logic [WIDTH-1:0]         cap_data,
  output logic [$clog2(DEPTH):0]   cap_level,
  output logic                     overflow,
  input  logic                     clear_overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic event_prev, edge_det, empty, full, push, pop, drop;
  logic [WIDTH-1:0] push_data;
  assign edge_det = EDGE == 0 ? event_in & ~event_prev :
                    EDGE == 1 ? ~event_in & event_prev : event_in ^ event_prev;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign pop = ~empty & cap_ready;
  // a pop in the same cycle frees the slot the push writes into
  assign push = edge_det & (~full | pop);
  assign drop = edge_det & full & ~pop;
  assign cap_valid = ~empty;
  assign cap_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
`ifdef CAPTURE_DELTA_EN
  logic [WIDTH-1:0] last_capture;
  assign push_data = counter - last_capture;
  // tracks every detected edge, dropped ones included, so deltas stay relative to the last event
  always_ff @(posedge clk)
    if (rst) last_capture <= '0;
    else if (edge_det) last_capture <= counter;
`else
  assign push_data = counter;
`endif
  // loaded during reset too, so a level held high across reset release is not an edge
  always_ff @(posedge clk) event_prev <= event_in;
  always_ff @(posedge clk)
    if (!rst && push) mem[wr_ptr[AW-1:0]] <= push_data;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cap_level <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cap_level <= cap_level + (AW+1)'(push) - (AW+1)'(pop);
      overflow  <= drop | (overflow & ~clear_overflow);
    end
endmodule

// File: tb/tb_counter_capture_fifo.sv
// tb_counter_capture_fifo: directed tests for counter_capture_fifo (EDGE=0 and EDGE=2 instances)
module tb_counter_capture_fifo;
  logic clk = 0, rst = 1, clr = 0;
  logic [15:0] counter = 0;
  logic ev0 = 0, rdy0 = 0, ev2 = 0, rdy2 = 0;
  logic v0, o0, v2, o2;
  logic [15:0] d0, d2;
  logic [2:0] l0, l2;
  int total = 0, bad = 0;
  logic [15:0] x1, x2, x3, x4, x5;

  always #5 clk = ~clk;

  counter_capture_fifo #(.WIDTH(16), .DEPTH(4), .EDGE(0)) dut0 (
    .clk(clk), .rst(rst), .counter(counter), .event_in(ev0), .cap_valid(v0),
    .cap_ready(rdy0), .cap_data(d0), .cap_level(l0), .overflow(o0), .clear_overflow(clr));
  counter_capture_fifo #(.WIDTH(16), .DEPTH(4), .EDGE(2)) dut2 (
    .clk(clk), .rst(rst), .counter(counter), .event_in(ev2), .cap_valid(v2),
    .cap_ready(rdy2), .cap_data(d2), .cap_level(l2), .overflow(o2), .clear_overflow(clr));

`ifdef CAPTURE_DELTA_EN
  logic [15:0] last0 = 0;
  function automatic logic [15:0] e0(input logic [15:0] c);
    e0 = c - last0;
    last0 = c;
  endfunction
`else
  function automatic logic [15:0] e0(input logic [15:0] c);
    e0 = c;
  endfunction
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pulse0(input logic [15:0] c);
    counter = c;
    ev0 = 1;
    tick;
    ev0 = 0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1;
    tick;
    tick;
    rst = 0;
    chk("reset valid", 16'(v0), 16'd0);
    chk("reset level", 16'(l0), 16'd0);
    chk("reset overflow", 16'(o0), 16'd0);
    chk("reset data", d0, 16'h0000);
    chk("reset valid2", 16'(v2), 16'd0);
  endtask

  task automatic test_basic;
    x1 = e0(16'h0100);
    counter = 16'h0100;
    ev0 = 1;
    rdy0 = 1;
    tick;
    chk("basic valid", 16'(v0), 16'd1);
    chk("basic data", d0, x1);
    chk("basic level", 16'(l0), 16'd1);
    ev0 = 0;
    tick;
    chk("basic popped valid", 16'(v0), 16'd0);
    chk("basic popped level", 16'(l0), 16'd0);
    rdy0 = 0;
  endtask

  task automatic test_order;
    x1 = e0(16'h0010); pulse0(16'h0010);
    x2 = e0(16'h0020); pulse0(16'h0020);
    x3 = e0(16'h0030); pulse0(16'h0030);
    chk("order level", 16'(l0), 16'd3);
    chk("order hold data", d0, x1);
    tick;
    chk("order stable data", d0, x1);
    rdy0 = 1;
    chk("order pop1", d0, x1);
    tick;
    chk("order pop2", d0, x2);
    tick;
    chk("order pop3", d0, x3);
    tick;
    chk("order empty", 16'(v0), 16'd0);
    rdy0 = 0;
  endtask

  task automatic test_overflow;
    x1 = e0(16'h0001); pulse0(16'h0001);
    x2 = e0(16'h0002); pulse0(16'h0002);
    x3 = e0(16'h0003); pulse0(16'h0003);
    x4 = e0(16'h0004); pulse0(16'h0004);
    chk("full no overflow", 16'(o0), 16'd0);
    x5 = e0(16'h0005); pulse0(16'h0005);
    chk("ovf level", 16'(l0), 16'd4);
    chk("ovf flag", 16'(o0), 16'd1);
    rdy0 = 1;
    chk("ovf pop1", d0, x1);
    tick;
    chk("ovf pop2", d0, x2);
    tick;
    chk("ovf pop3", d0, x3);
    tick;
    chk("ovf pop4", d0, x4);
    tick;
    chk("ovf fifth absent", 16'(v0), 16'd0);
    rdy0 = 0;
    clr = 1;
    tick;
    clr = 0;
    chk("ovf cleared", 16'(o0), 16'd0);
    x1 = e0(16'h0011); pulse0(16'h0011);
    x2 = e0(16'h0012); pulse0(16'h0012);
    x3 = e0(16'h0013); pulse0(16'h0013);
    x4 = e0(16'h0014); pulse0(16'h0014);
    x5 = e0(16'h0015);
    counter = 16'h0015;
    ev0 = 1;
    clr = 1;
    tick;
    chk("ovf set wins", 16'(o0), 16'd1);
    ev0 = 0;
    clr = 0;
    tick;
    chk("ovf still set", 16'(o0), 16'd1);
    chk("ovf full level", 16'(l0), 16'd4);
    clr = 1;
    tick;
    clr = 0;
    chk("ovf cleared2", 16'(o0), 16'd0);
  endtask

  task automatic test_full_push_pop;
    x5 = e0(16'h0077);
    counter = 16'h0077;
    ev0 = 1;
    rdy0 = 1;
    tick;
    chk("fpp level", 16'(l0), 16'd4);
    chk("fpp overflow", 16'(o0), 16'd0);
    chk("fpp head", d0, x2);
    ev0 = 0;
    tick;
    chk("fpp pop3", d0, x3);
    tick;
    chk("fpp pop4", d0, x4);
    tick;
    chk("fpp new last", d0, x5);
    tick;
    chk("fpp empty", 16'(v0), 16'd0);
    rdy0 = 0;
  endtask

  task automatic test_edge_both_reset;
    rst = 1;
    ev2 = 1;
    tick;
    rst = 0;
`ifdef CAPTURE_DELTA_EN
    last0 = 0;
`endif
    tick;
    tick;
    chk("held high no capture", 16'(l2), 16'd0);
    counter = 16'h000A;
    ev2 = 0;
    tick;
    counter = 16'h000B;
    ev2 = 1;
    tick;
    chk("both level", 16'(l2), 16'd2);
    chk("both head", d2, 16'h000A);
    rst = 1;
    ev2 = 0;
    tick;
    chk("rst valid2", 16'(v2), 16'd0);
    chk("rst level2", 16'(l2), 16'd0);
    rst = 0;
    tick;
    chk("rst edge ignored", 16'(l2), 16'd0);
  endtask

  task automatic test_wrap;
    logic [15:0] second;
`ifdef CAPTURE_DELTA_EN
    second = 16'h0020;
`else
    second = 16'h0010;
`endif
    pulse0(16'hFFF0);
    pulse0(16'h0010);
    chk("wrap level", 16'(l0), 16'd2);
    chk("wrap first", d0, 16'hFFF0);
    rdy0 = 1;
    tick;
    chk("wrap second", d0, second);
    tick;
    rdy0 = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_order;
    test_overflow;
    test_full_push_pop;
    test_edge_both_reset;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
